// File: rtl/duck_sprite_sequencer.sv
// ============================================================================
// duck_sprite_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Upstream driver of the duck sprite ROM bank.
//   - Runs the per-duck animation state machine (IDLE/FLY/HIT/FALL/DONE) and
//     selects the 5-bit sprite frame index shown to the ROM bank.
//   - Turns the VGA scan position into a 14-bit sprite ROM address, using the
//     frame width/height that the ROM bank reports back for that frame.
//   - Aligns the registered in-box flag with the ROM's 1-cycle-latency colour
//     index and emits the duck pixel-on flag and colour for the colour mapper.
//
// Parameters:
//   ANIM_DIV        frame_tick pulses per flap step while flying
//   HIT_TICKS       frame_tick pulses the shot frame is held before falling
//   TRANSPARENT_IDX ROM colour index that is treated as see-through
//
// Ports:
//   clock, reset       system clock, asynchronous active-high reset
//   frame_tick         one-cycle pulse per video frame
//   spawn, shot        start a new duck / duck was hit (sampled every cycle)
//   landed             motion block reports the duck reached the ground
//   diag               0 = level flight cycle, 1 = diagonal flight cycle
//   DrawX, DrawY       current pixel column / row
//   duck_x, duck_y     sprite top-left column / row
//   DuckSizeX/Y        width / height of the current frame (from ROM bank)
//   dir_left           (DUCK_MIRROR_EN only) mirror the sprite horizontally
//   q                  ROM colour index, valid 1 cycle after address
//   frame              ROM frame select
//   address            ROM address (0 outside the sprite box)
//   duck_on            draw the duck at the pixel presented 1 cycle earlier
//   duck_color         colour index accompanying duck_on (0 when off)
//   state              IDLE=0, FLY=1, HIT=2, FALL=3, DONE=4
//   done               one-cycle pulse when a fall completes
//
// Build option:
//   DUCK_MIRROR_EN  adds the dir_left input; when it is high the sprite column
//                   is mirrored so the duck faces left. Without the macro the
//                   port does not exist and columns are never mirrored.
// ============================================================================
module duck_sprite_sequencer #(
    parameter int         ANIM_DIV        = 6,
    parameter int         HIT_TICKS       = 30,
    parameter logic [3:0] TRANSPARENT_IDX = 4'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        spawn,
    input  logic        shot,
    input  logic        landed,
    input  logic        diag,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  duck_x,
    input  logic [9:0]  duck_y,
    input  logic [6:0]  DuckSizeX,
    input  logic [6:0]  DuckSizeY,
`ifdef DUCK_MIRROR_EN
    input  logic        dir_left,
`endif
    input  logic [3:0]  q,
    output logic [4:0]  frame,
    output logic [13:0] address,
    output logic        duck_on,
    output logic [3:0]  duck_color,
    output logic [2:0]  state,
    output logic        done
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam int ANIM_W = (ANIM_DIV  > 1) ? $clog2(ANIM_DIV)  : 1;
    localparam int HOLD_W = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;

    localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HIT_TICKS - 1);

    localparam logic [4:0] FRAME_LEVEL_BASE = 5'd0;
    localparam logic [4:0] FRAME_DIAG_BASE  = 5'd4;
    localparam logic [4:0] FRAME_SHOT       = 5'd8;
    localparam logic [4:0] FRAME_FALL       = 5'd9;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FLY  = 3'd1,
        HIT  = 3'd2,
        FALL = 3'd3,
        DONE = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------------
    state_t              state_q,      state_d;
    logic [4:0]          frame_q,      frame_d;
    logic [ANIM_W-1:0]   anim_q,       anim_d;
    logic [HOLD_W-1:0]   hold_q,       hold_d;
    logic                spawn_pend_q, spawn_pend_d;
    logic                shot_pend_q,  shot_pend_d;
    logic                done_q,       done_d;
    logic                in_box_q,     in_box_d;

    // Event seen either earlier (pending) or on this very cycle
    logic                spawn_seen;
    logic                shot_seen;

    // Address-path intermediates
    logic                sprite_active;
    logic [10:0]         x_end;
    logic [10:0]         y_end;
    logic                x_inside;
    logic                y_inside;
    logic [6:0]          col_raw;
    logic [6:0]          col;
    logic [6:0]          row;
    logic [13:0]         row_base;
    logic [13:0]         addr_sum;

    // ------------------------------------------------------------------------
    // Animation state machine: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        anim_d       = anim_q;
        hold_d       = hold_q;
        spawn_pend_d = spawn_pend_q;
        shot_pend_d  = shot_pend_q;
        done_d       = 1'b0;

        // A request that lands on a tick cycle is honoured on that tick;
        // otherwise it is remembered until the next tick.
        spawn_seen   = spawn_pend_q | spawn;
        shot_seen    = shot_pend_q  | shot;

        unique case (state_q)
            IDLE: begin
                spawn_pend_d = spawn_seen;
                if (frame_tick && spawn_seen) begin
                    state_d      = FLY;
                    frame_d      = diag ? FRAME_DIAG_BASE : FRAME_LEVEL_BASE;
                    anim_d       = '0;
                    spawn_pend_d = 1'b0;
                end
            end

            FLY: begin
                shot_pend_d = shot_seen;
                if (frame_tick) begin
                    if (shot_seen) begin
                        // Being shot wins over a flap step on the same tick.
                        state_d     = HIT;
                        frame_d     = FRAME_SHOT;
                        hold_d      = '0;
                        shot_pend_d = 1'b0;
                    end else if (anim_q == ANIM_LAST) begin
                        anim_d  = '0;
                        // Flap phase is frame[1:0]; diag picks the bank of
                        // four, so a diag change re-bases at this step.
                        frame_d = {2'b00, diag, frame_q[1:0] + 2'd1};
                    end else begin
                        anim_d = anim_q + ANIM_W'(1);
                    end
                end
            end

            HIT: begin
                if (frame_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = FALL;
                        frame_d = FRAME_FALL;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end

            FALL: begin
                if (frame_tick && landed) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // Leaves on the very next clock without waiting for a tick.
                state_d = IDLE;
                frame_d = FRAME_LEVEL_BASE;
                done_d  = 1'b1;
            end

            default: begin
                state_d = IDLE;
                frame_d = FRAME_LEVEL_BASE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Address path: sprite bounding box and ROM address
    // ------------------------------------------------------------------------
    always_comb begin
        sprite_active = (state_q == FLY) || (state_q == HIT) || (state_q == FALL);

        // 11-bit right/bottom edges so a sprite near the screen edge does not
        // wrap back round to column/row 0.
        x_end    = {1'b0, duck_x} + {4'b0000, DuckSizeX};
        y_end    = {1'b0, duck_y} + {4'b0000, DuckSizeY};

        x_inside = (DrawX >= duck_x) && ({1'b0, DrawX} < x_end);
        y_inside = (DrawY >= duck_y) && ({1'b0, DrawY} < y_end);

        // A zero width marks an invalid frame; never draw it.
        in_box_d = sprite_active && (DuckSizeX != 7'd0) && x_inside && y_inside;

        // Offsets inside the box are below 128, so the low 7 bits suffice.
        col_raw  = DrawX[6:0] - duck_x[6:0];
        row      = DrawY[6:0] - duck_y[6:0];

`ifdef DUCK_MIRROR_EN
        col      = dir_left ? (DuckSizeX - 7'd1 - col_raw) : col_raw;
`else
        col      = col_raw;
`endif

        row_base = {7'd0, row} * {7'd0, DuckSizeX};
        addr_sum = row_base + {7'd0, col};
        address  = in_box_d ? addr_sum : 14'd0;
    end

    // ------------------------------------------------------------------------
    // Pixel output: the registered in-box flag lines up with the ROM data
    // returned for the address issued on the previous cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        duck_on    = in_box_q && (q != TRANSPARENT_IDX);
        duck_color = duck_on ? q : 4'd0;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            frame_q      <= 5'd0;
            anim_q       <= '0;
            hold_q       <= '0;
            spawn_pend_q <= 1'b0;
            shot_pend_q  <= 1'b0;
            done_q       <= 1'b0;
            in_box_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            anim_q       <= anim_d;
            hold_q       <= hold_d;
            spawn_pend_q <= spawn_pend_d;
            shot_pend_q  <= shot_pend_d;
            done_q       <= done_d;
            in_box_q     <= in_box_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign state = state_q;
    assign frame = frame_q;
    assign done  = done_q;

endmodule

// File: tb/tb_duck_sprite_sequencer.sv
// ============================================================================
// tb_duck_sprite_sequencer
// ----------------------------------------------------------------------------
// Self-checking bench for duck_sprite_sequencer. A behavioural model tracks the
// duck's life cycle and computes the expected sprite address and pixel flags
// from the box geometry; every cycle the DUT outputs are compared against it.
// Directed sequences with literal expectations come first, then a long run of
// randomized stimulus. Define DUCK_MIRROR_EN to exercise the mirrored build.
// ============================================================================
module tb_duck_sprite_sequencer;

    localparam int ANIM_DIV  = 6;
    localparam int HIT_TICKS = 30;

    // DUT connections
    logic        clock = 1'b0;
    logic        reset;
    logic        frame_tick, spawn, shot, landed, diag;
    logic [9:0]  DrawX, DrawY, duck_x, duck_y;
    logic [6:0]  DuckSizeX, DuckSizeY;
    logic [3:0]  q;
    logic        dir_left;
    logic [4:0]  frame;
    logic [13:0] address;
    logic        duck_on;
    logic [3:0]  duck_color;
    logic [2:0]  state;
    logic        done;

    // Stimulus staged by the sequences, applied at the next falling edge
    logic        s_reset, s_tick, s_spawn, s_shot, s_landed, s_diag, s_dir;
    logic [9:0]  s_drawx, s_drawy, s_duck_x, s_duck_y;
    logic [6:0]  s_size_x, s_size_y;
    logic [3:0]  s_q;

    // Behavioural model of the duck's life
    int m_state, m_frame, m_anim, m_hold;
    bit m_spawn_pend, m_shot_pend, m_done, m_inbox_prev;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    duck_sprite_sequencer #(
        .ANIM_DIV       (ANIM_DIV),
        .HIT_TICKS      (HIT_TICKS),
        .TRANSPARENT_IDX(4'd0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .spawn      (spawn),
        .shot       (shot),
        .landed     (landed),
        .diag       (diag),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .duck_x     (duck_x),
        .duck_y     (duck_y),
        .DuckSizeX  (DuckSizeX),
        .DuckSizeY  (DuckSizeY),
`ifdef DUCK_MIRROR_EN
        .dir_left   (dir_left),
`endif
        .q          (q),
        .frame      (frame),
        .address    (address),
        .duck_on    (duck_on),
        .duck_color (duck_color),
        .state      (state),
        .done       (done)
    );

    // ------------------------------------------------------------------------
    // Comparison helper
    // ------------------------------------------------------------------------
    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Model: geometry from the box rules
    // ------------------------------------------------------------------------
    function automatic bit modelInBox();
        int dx, dy, x0, y0, sx, sy;
        dx = int'(DrawX);    dy = int'(DrawY);
        x0 = int'(duck_x);   y0 = int'(duck_y);
        sx = int'(DuckSizeX); sy = int'(DuckSizeY);
        return (m_state >= 1 && m_state <= 3) && sx != 0 &&
               dx >= x0 && dx < x0 + sx && dy >= y0 && dy < y0 + sy;
    endfunction

    function automatic int modelAddress();
        int c, r;
        if (!modelInBox()) return 0;
        c = int'(DrawX) - int'(duck_x);
        r = int'(DrawY) - int'(duck_y);
`ifdef DUCK_MIRROR_EN
        if (dir_left) c = int'(DuckSizeX) - 1 - c;
`endif
        return (r * int'(DuckSizeX) + c) % 16384;
    endfunction

    task automatic modelReset();
        m_state = 0; m_frame = 0; m_anim = 0; m_hold = 0;
        m_spawn_pend = 0; m_shot_pend = 0; m_done = 0; m_inbox_prev = 0;
    endtask

    // Advance the model across one rising edge using the applied inputs
    task automatic modelStep();
        bit inbox_now, pend;
        if (reset) begin
            modelReset();
            return;
        end
        inbox_now = modelInBox();
        m_done    = (m_state == 4);
        case (m_state)
            0: begin
                pend = m_spawn_pend || spawn;
                if (frame_tick && pend) begin
                    m_state = 1; m_frame = diag ? 4 : 0; m_anim = 0; m_spawn_pend = 0;
                end else begin
                    m_spawn_pend = pend;
                end
            end
            1: begin
                pend = m_shot_pend || shot;
                if (frame_tick) begin
                    m_shot_pend = 0;
                    if (pend) begin
                        m_state = 2; m_frame = 8; m_hold = 0;
                    end else begin
                        m_anim++;
                        if (m_anim == ANIM_DIV) begin
                            m_anim  = 0;
                            m_frame = (diag ? 4 : 0) + ((m_frame % 4) + 1) % 4;
                        end
                    end
                end else begin
                    m_shot_pend = pend;
                end
            end
            2: begin
                if (frame_tick) begin
                    m_hold++;
                    if (m_hold == HIT_TICKS) begin
                        m_state = 3; m_frame = 9;
                    end
                end
            end
            3: if (frame_tick && landed) m_state = 4;
            default: begin
                m_state = 0; m_frame = 0;
            end
        endcase
        m_inbox_prev = inbox_now;
    endtask

    // ------------------------------------------------------------------------
    // Per-cycle comparison against the model
    // ------------------------------------------------------------------------
    task automatic checkOutput();
        bit exp_on;
        exp_on = m_inbox_prev && (q != 4'd0);
        check("state",      int'(state),      m_state);
        check("frame",      int'(frame),      m_frame);
        check("done",       int'(done),       int'(m_done));
        check("address",    int'(address),    modelAddress());
        check("duck_on",    int'(duck_on),    int'(exp_on));
        check("duck_color", int'(duck_color), exp_on ? int'(q) : 0);
    endtask

    // Apply the staged stimulus mid-cycle, compare, then step the model
    task automatic applyStimulus();
        @(negedge clock);
        reset      = s_reset;
        frame_tick = s_tick;
        spawn      = s_spawn;
        shot       = s_shot;
        landed     = s_landed;
        diag       = s_diag;
        dir_left   = s_dir;
        DrawX      = s_drawx;
        DrawY      = s_drawy;
        duck_x     = s_duck_x;
        duck_y     = s_duck_y;
        DuckSizeX  = s_size_x;
        DuckSizeY  = s_size_y;
        q          = s_q;
        #1;
        if (reset) modelReset();
        checkOutput();
        modelStep();
    endtask

    task automatic clearControls();
        s_reset = 0; s_tick = 0; s_spawn = 0; s_shot = 0; s_landed = 0;
    endtask

    task automatic tickCycle();
        s_tick = 1; applyStimulus(); s_tick = 0;
    endtask

    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int exp_seq[4];
        exp_seq = '{1, 2, 3, 0};

        reset = 1'b1;
        frame_tick = 0; spawn = 0; shot = 0; landed = 0; diag = 0; dir_left = 0;
        DrawX = 0; DrawY = 0; duck_x = 0; duck_y = 0; DuckSizeX = 0; DuckSizeY = 0; q = 0;
        modelReset();

        clearControls();
        s_diag = 0; s_dir = 0;
        s_duck_x = 10'd100; s_duck_y = 10'd50; s_drawx = 10'd110; s_drawy = 10'd60;
        s_size_x = 7'd68;   s_size_y = 7'd64;  s_q = 4'd5;

        // Reset state
        s_reset = 1; applyStimulus(); applyStimulus();
        check("reset_state",   int'(state),   0);
        check("reset_frame",   int'(frame),   0);
        check("reset_duck_on", int'(duck_on), 0);
        check("reset_done",    int'(done),    0);
        s_reset = 0;

        // Spawn between ticks, then a level flap cycle
        s_spawn = 1; applyStimulus(); s_spawn = 0;
        check("spawn_waits_tick", int'(state), 0);
        tickCycle();
        applyStimulus();
        check("fly_state", int'(state), 1);
        check("fly_frame", int'(frame), 0);
        for (int k = 1; k <= 24; k++) begin
            tickCycle();
            applyStimulus();
            if (k == 3) check("frame_hold_between_steps", int'(frame), 0);
            if (k % 6 == 0) check("flap_frame", int'(frame), exp_seq[k / 6 - 1]);
        end

        // Reset mid-flight at frame 2
        for (int k = 0; k < 12; k++) tickCycle();
        applyStimulus();
        check("pre_reset_frame",   int'(frame),   2);
        check("pre_reset_duck_on", int'(duck_on), 1);
        s_reset = 1; applyStimulus();
        check("midfly_reset_state",   int'(state),   0);
        check("midfly_reset_frame",   int'(frame),   0);
        check("midfly_reset_duck_on", int'(duck_on), 0);
        s_reset = 0;

        // Shot, hold, fall, land
        s_spawn = 1; applyStimulus(); s_spawn = 0;
        tickCycle();
        s_shot = 1; applyStimulus(); s_shot = 0;
        applyStimulus();
        check("shot_waits_tick", int'(state), 1);
        tickCycle();
        applyStimulus();
        check("hit_state", int'(state), 2);
        check("hit_frame", int'(frame), 8);
        for (int k = 0; k < 29; k++) tickCycle();
        applyStimulus();
        check("hit_still_held", int'(state), 2);
        tickCycle();
        applyStimulus();
        check("fall_state", int'(state), 3);
        check("fall_frame", int'(frame), 9);
        s_landed = 1; tickCycle(); s_landed = 0;
        applyStimulus();
        check("done_state", int'(state), 4);
        applyStimulus();
        check("done_pulse",     int'(done),  1);
        check("back_to_idle",   int'(state), 0);
        check("idle_frame",     int'(frame), 0);
        applyStimulus();
        check("done_one_cycle", int'(done),  0);

        // Address path: diagonal frame 4, 68x64 box at (100,50)
        s_diag = 1;
        s_spawn = 1; applyStimulus(); s_spawn = 0;
        tickCycle();
        s_drawx = 10'd167; s_drawy = 10'd113; s_q = 4'd3;
        applyStimulus();
        check("diag_frame", int'(frame), 4);
`ifdef DUCK_MIRROR_EN
        check("corner_address", int'(address), 63 * 68);
`else
        check("corner_address", int'(address), 4351);
`endif
        s_drawx = 10'd168; s_q = 4'd5;
        applyStimulus();
        check("outside_address", int'(address),    0);
        check("pipe_duck_on",    int'(duck_on),    1);
        check("pipe_duck_color", int'(duck_color), 5);
        s_drawx = 10'd120;
        applyStimulus();
        check("outside_then_off", int'(duck_on), 0);
        s_q = 4'd0;
        applyStimulus();
        check("transparent_off",   int'(duck_on),    0);
        check("transparent_color", int'(duck_color), 0);

        // Right-screen-edge box: no wrap in the bounds compare
        s_duck_x = 10'd600; s_duck_y = 10'd50; s_drawx = 10'd630; s_drawy = 10'd50;
        s_size_x = 7'd64; s_size_y = 7'd64;
`ifdef DUCK_MIRROR_EN
        s_dir = 1;
        applyStimulus();
        check("edge_col_mirror", int'(address), 33);
        s_dir = 0;
`else
        applyStimulus();
        check("edge_col", int'(address), 30);
`endif
        s_duck_x = 10'd1000; s_drawx = 10'd5; s_q = 4'd5;
        applyStimulus();
        check("no_wrap_address", int'(address), 0);
        applyStimulus();
        check("no_wrap_duck_on", int'(duck_on), 0);
        s_duck_x = 10'd200; s_drawx = 10'd200; s_size_x = 7'd0;
        applyStimulus();
        check("zero_width_address", int'(address), 0);
        applyStimulus();
        check("zero_width_duck_on", int'(duck_on), 0);
        s_diag = 0;

        // Randomized traffic, checked every cycle against the model
        for (int n = 0; n < 4000; n++) begin
            s_reset  = ($urandom_range(0, 699) == 0);
            s_tick   = ($urandom_range(0, 2)   == 0);
            s_spawn  = ($urandom_range(0, 7)   == 0);
            s_shot   = ($urandom_range(0, 59)  == 0);
            s_landed = ($urandom_range(0, 3)   == 0);
            if ($urandom_range(0, 39) == 0) s_diag = ~s_diag;
            s_dir    = 1'($urandom_range(0, 1));
            s_duck_x = 10'($urandom_range(0, 1023));
            s_duck_y = 10'($urandom_range(0, 1023));
            s_size_x = ($urandom_range(0, 19) == 0) ? 7'd0 : 7'($urandom_range(1, 68));
            s_size_y = 7'($urandom_range(1, 64));
            s_drawx  = 10'(int'(s_duck_x) + int'($urandom_range(0, 80)) - 5);
            s_drawy  = 10'(int'(s_duck_y) + int'($urandom_range(0, 72)) - 4);
            s_q      = 4'($urandom_range(0, 15));
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
